// File: rtl/posit_pkg.sv
// Shared posit definitions: pd stream variants, field widths and special encodings.
package posit_pkg;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    WIDE   = 1'b1
  } pd_type_t;

  // Largest representable scale: (N-2) regime steps of 2^ES each.
  function automatic int get_maxscale(input int n, input int es);
    return (n - 2) << es;
  endfunction

  // Signed scale width: covers +/-maxscale plus headroom for out-of-range values.
  function automatic int get_scale_width(input int n, input int es, input pd_type_t t);
    int w;
    w = $clog2(get_maxscale(n, es) + 1) + 2;
    if (t == WIDE) w = w + 2;
    return w;
  endfunction

  // Fraction width: the most fraction bits any posit of this size can hold.
  function automatic int get_fraction_width(input int n, input int es, input pd_type_t t);
    int w;
    w = n - 3 - es;
    if (t == WIDE) w = w + 4;
    return w;
  endfunction

  function automatic logic [63:0] posit_nar(input int n);
    return 64'(1) << (n - 1);
  endfunction

  function automatic logic [63:0] posit_maxpos(input int n);
    return (64'(1) << (n - 1)) - 64'(1);
  endfunction

  function automatic logic [63:0] posit_minpos();
    return 64'(1);
  endfunction

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even incrementer on the posit magnitude, saturating at maxpos
// and never collapsing a non-zero magnitude to zero.
module posit_round_rne #(
  parameter int MW = 15
) (
  input  logic [MW-1:0] i_mag,
  input  logic          i_guard,
  input  logic          i_sticky,
  output logic [MW-1:0] o_mag
);

  logic          w_inc;
  logic [MW:0]   w_sum;

  // Increment on G & (L | S); a carry out of the magnitude clamps to maxpos.
  always_comb begin
    w_inc = i_guard & (i_mag[0] | i_sticky);
    w_sum = {1'b0, i_mag} + {{MW{1'b0}}, w_inc};
    if (w_sum[MW])
      o_mag = '1;
    else if (w_sum[MW-1:0] == '0)
      o_mag = MW'(1);
    else
      o_mag = w_sum[MW-1:0];
  end

endmodule

// File: rtl/posit_encoder_stream.sv
// Tail of the arithmetic pipeline: packs decoded posit fields into a posit word.
// S1 builds regime|exp|fraction and extracts L/G/S; S2 rounds, negates and
// applies NaR/zero. One global stall freezes both stages.
module posit_encoder_stream import posit_pkg::*; #(
  parameter int       POSIT_WIDTH = 16,
  parameter int       POSIT_ES    = 1,
  parameter pd_type_t PD_TYPE     = NORMAL,
  localparam int      SW = get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE),
  localparam int      FW = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_rts,
  output logic                   in_rtr,
  input  logic                   in_sow,
  input  logic                   in_eow,
  input  logic signed [SW-1:0]   in_scale,
  input  logic [FW-1:0]          in_fraction,
  input  logic                   in_NaR,
  input  logic                   in_sign,
  input  logic                   in_zero,
  input  logic                   in_guard,
  input  logic                   in_round,
  input  logic                   in_sticky,
  output logic                   out_rts,
  input  logic                   out_rtr,
  output logic                   out_sow,
  output logic                   out_eow,
  output logic [POSIT_WIDTH-1:0] out_posit
);

  localparam int N   = POSIT_WIDTH;
  localparam int ES  = POSIT_ES;
  localparam int MW  = N - 1;
  localparam int TW  = ES + FW + 3;
  // Padding below the tail keeps every shifted-out bit visible to sticky.
  localparam int PAD = N;
  localparam int VW  = 2 + TW + PAD;

  localparam logic signed [SW-1:0] MAXSCALE = SW'(get_maxscale(N, ES));
  localparam logic [N-1:0]         P_NAR    = N'(posit_nar(N));
  localparam logic [N-1:0]         P_MAXPOS = N'(posit_maxpos(N));
  localparam logic [N-1:0]         P_MINPOS = N'(posit_minpos());

  logic                  w_stall;
  logic signed [SW-1:0]  w_k;
  logic [SW-1:0]         w_amt;
  logic [TW-1:0]         w_tail;
  logic signed [VW-1:0]  w_vec;
  logic signed [VW-1:0]  w_shift;
  logic [MW-1:0]         w_mag;
  logic                  w_g;
  logic                  w_s;
  logic [MW-1:0]         w_rounded;
  logic [N-1:0]          w_posit;

  logic                  r_s1_valid;
  logic [MW-1:0]         r_s1_mag;
  logic                  r_s1_g;
  logic                  r_s1_s;
  logic                  r_s1_sign;
  logic                  r_s1_nar;
  logic                  r_s1_zero;
  logic                  r_s1_sow;
  logic                  r_s1_eow;
  logic                  r_out_rts;
  logic                  r_out_sow;
  logic                  r_out_eow;
  logic [N-1:0]          r_out_posit;

  assign w_stall = r_out_rts & ~out_rtr;
  assign in_rtr  = ~w_stall;

  // Regime: a "10" seed sign-extended right by k gives k+1 ones then 0; a "01"
  // seed zero-filled right by -k-1 (= ~k) gives -k zeros then 1.
  assign w_k     = in_scale >>> ES;
  assign w_amt   = w_k[SW-1] ? ~w_k : w_k;
  assign w_tail  = {in_scale[ES-1:0], in_fraction, in_guard, in_round, in_sticky};
  assign w_vec   = {(w_k[SW-1] ? 2'b01 : 2'b10), w_tail, {PAD{1'b0}}};
  assign w_shift = w_vec >>> w_amt;

  // S1 truncation to N-1 kept bits with G/S, overridden by scale saturation.
  always_comb begin
    w_mag = w_shift[VW-1 -: MW];
    w_g   = w_shift[VW-N];
    w_s   = |w_shift[VW-N-1:0];
    if (in_scale > MAXSCALE) begin
      w_mag = P_MAXPOS[MW-1:0];
      w_g   = 1'b0;
      w_s   = 1'b0;
    end else if (in_scale < -MAXSCALE) begin
      w_mag = P_MINPOS[MW-1:0];
      w_g   = 1'b0;
      w_s   = 1'b0;
    end
  end

  posit_round_rne #(.MW(MW)) u_round (
    .i_mag    (r_s1_mag),
    .i_guard  (r_s1_g),
    .i_sticky (r_s1_s),
    .o_mag    (w_rounded)
  );

  // S2 result: NaR beats zero; otherwise sign-applied rounded magnitude.
  always_comb begin
    w_posit = {1'b0, w_rounded};
    if (r_s1_nar)
      w_posit = P_NAR;
    else if (r_s1_zero)
      w_posit = '0;
    else if (r_s1_sign)
      w_posit = ~{1'b0, w_rounded} + N'(1);
  end

  // Both pipeline stages advance together unless the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_mag    <= '0;
      r_s1_g      <= 1'b0;
      r_s1_s      <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_nar    <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_sow    <= 1'b0;
      r_s1_eow    <= 1'b0;
      r_out_rts   <= 1'b0;
      r_out_sow   <= 1'b0;
      r_out_eow   <= 1'b0;
      r_out_posit <= '0;
    end else if (!w_stall) begin
      r_s1_valid  <= in_rts;
      r_s1_mag    <= w_mag;
      r_s1_g      <= w_g;
      r_s1_s      <= w_s;
      r_s1_sign   <= in_sign;
      r_s1_nar    <= in_NaR;
      r_s1_zero   <= in_zero;
      r_s1_sow    <= in_sow;
      r_s1_eow    <= in_eow;
      r_out_rts   <= r_s1_valid;
      r_out_sow   <= r_s1_valid & r_s1_sow;
      r_out_eow   <= r_s1_valid & r_s1_eow;
      r_out_posit <= r_s1_valid ? w_posit : '0;
    end
  end

  assign out_rts   = r_out_rts;
  assign out_sow   = r_out_sow;
  assign out_eow   = r_out_eow;
  assign out_posit = r_out_posit;

endmodule

// File: tb/tb_posit_encoder_stream.sv
// Directed bench for posit_encoder_stream (N=16, ES=1, NORMAL).
module tb_posit_encoder_stream;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_rts, in_rtr, in_sow, in_eow;
  logic signed [6:0]  in_scale;
  logic [11:0]        in_fraction;
  logic               in_NaR, in_sign, in_zero, in_guard, in_round, in_sticky;
  logic               out_rts, out_rtr, out_sow, out_eow;
  logic [15:0]        out_posit;

  posit_encoder_stream #(.POSIT_WIDTH(16), .POSIT_ES(1)) dut (
    .clk(clk), .rst(rst),
    .in_rts(in_rts), .in_rtr(in_rtr), .in_sow(in_sow), .in_eow(in_eow),
    .in_scale(in_scale), .in_fraction(in_fraction), .in_NaR(in_NaR),
    .in_sign(in_sign), .in_zero(in_zero), .in_guard(in_guard),
    .in_round(in_round), .in_sticky(in_sticky),
    .out_rts(out_rts), .out_rtr(out_rtr), .out_sow(out_sow),
    .out_eow(out_eow), .out_posit(out_posit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [6:0] scale;
    logic [11:0]       frac;
    logic              sign, nar, zero, g, r, s;
    logic [15:0]       exp;
  } vec_t;

  typedef struct packed {
    logic [15:0] p;
    logic        sow;
    logic        eow;
  } exp_t;

  localparam int NV = 19;
  vec_t        vecs [NV];
  exp_t        sb [$];
  exp_t        e_pop;
  logic [15:0] cur_exp;
  logic [15:0] held;
  int          n_total = 0;
  int          n_bad   = 0;
  int          n_rx    = 0;
  int          rx_base;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input int sc, input logic [11:0] f, input logic sg, input logic nr,
                              input logic zr, input logic g, input logic r, input logic s,
                              input logic [15:0] ex);
    vec_t v;
    v.scale = 7'(sc); v.frac = f; v.sign = sg; v.nar = nr; v.zero = zr;
    v.g = g; v.r = r; v.s = s; v.exp = ex;
    return v;
  endfunction

  // Scoreboard: pop/compare on output transfers, push on input transfers.
  always @(negedge clk) begin
    if (!rst && out_rts && out_rtr) begin
      check_eq($sformatf("sb_has_w%0d", n_rx), 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e_pop = sb.pop_front();
        check_eq($sformatf("posit_w%0d", n_rx), 32'(out_posit), 32'(e_pop.p));
        check_eq($sformatf("sow_w%0d", n_rx), 32'(out_sow), 32'(e_pop.sow));
        check_eq($sformatf("eow_w%0d", n_rx), 32'(out_eow), 32'(e_pop.eow));
      end
      n_rx++;
    end
    if (!rst && in_rts && in_rtr)
      sb.push_back('{p: cur_exp, sow: in_sow, eow: in_eow});
  end

  task automatic send(input vec_t v, input logic sow, input logic eow);
    int t;
    in_scale = v.scale; in_fraction = v.frac; in_sign = v.sign; in_NaR = v.nar;
    in_zero = v.zero; in_guard = v.g; in_round = v.r; in_sticky = v.s;
    cur_exp = v.exp; in_sow = sow; in_eow = eow; in_rts = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_rtr && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_rtr) check_eq("send_timeout", 32'(in_rtr), 1);
    @(posedge clk); #1;
    in_rts = 1'b0; in_sow = 1'b0; in_eow = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("drain_empty", 32'(sb.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(  0, 12'h000, 0, 0, 0, 0, 0, 0, 16'h4000);
    vecs[1]  = mk(  1, 12'h000, 0, 0, 0, 0, 0, 0, 16'h5000);
    vecs[2]  = mk(  0, 12'h800, 0, 0, 0, 0, 0, 0, 16'h4800);
    vecs[3]  = mk(  0, 12'h000, 1, 0, 0, 0, 0, 0, 16'hC000);
    vecs[4]  = mk(  0, 12'h000, 1, 1, 1, 0, 0, 0, 16'h8000);
    vecs[5]  = mk(  0, 12'h000, 1, 0, 1, 0, 0, 0, 16'h0000);
    vecs[6]  = mk( 40, 12'h000, 0, 0, 0, 0, 0, 0, 16'h7FFF);
    vecs[7]  = mk(-40, 12'h000, 0, 0, 0, 0, 0, 0, 16'h0001);
    vecs[8]  = mk( 28, 12'hFFF, 0, 0, 0, 1, 0, 0, 16'h7FFF);
    vecs[9]  = mk(  0, 12'h000, 0, 0, 0, 1, 0, 0, 16'h4000);
    vecs[10] = mk(  0, 12'h000, 0, 0, 0, 1, 0, 1, 16'h4001);
    vecs[11] = mk(  0, 12'h001, 0, 0, 0, 1, 0, 0, 16'h4002);
    vecs[12] = mk( -1, 12'h000, 0, 0, 0, 0, 0, 0, 16'h3000);
    vecs[13] = mk(  2, 12'h000, 0, 0, 0, 0, 0, 0, 16'h6000);
    vecs[14] = mk(  1, 12'h800, 1, 0, 0, 0, 0, 0, 16'hA800);
    vecs[15] = mk(-28, 12'h000, 0, 0, 0, 0, 0, 0, 16'h0001);
    vecs[16] = mk( 27, 12'h000, 0, 0, 0, 0, 0, 0, 16'h7FFE);
    vecs[17] = mk( 40, 12'h000, 1, 0, 0, 0, 0, 0, 16'h8001);
    vecs[18] = mk(  0, 12'h000, 0, 0, 0, 1, 1, 0, 16'h4001);

    rst = 1'b1; in_rts = 1'b0; in_sow = 1'b0; in_eow = 1'b0; in_scale = '0;
    in_fraction = '0; in_NaR = 1'b0; in_sign = 1'b0; in_zero = 1'b0;
    in_guard = 1'b0; in_round = 1'b0; in_sticky = 1'b0; out_rtr = 1'b1;
    cur_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_rts", 32'(out_rts), 0);
    check_eq("rst_out_posit", 32'(out_posit), 0);
    check_eq("rst_out_sow", 32'(out_sow), 0);
    check_eq("rst_out_eow", 32'(out_eow), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_in_rtr", 32'(in_rtr), 1);

    // Latency: word appears after exactly two edges.
    send(vecs[0], 1'b0, 1'b0);
    @(negedge clk);
    check_eq("lat1_rts", 32'(out_rts), 0);
    @(posedge clk); #1;
    check_eq("lat2_rts", 32'(out_rts), 1);
    check_eq("lat2_posit", 32'(out_posit), 32'h4000);

    // All vectors back-to-back at full rate.
    for (int i = 0; i < NV; i++) send(vecs[i], 1'b0, 1'b0);
    wait_drain();
    check_eq("rx_count_stream", 32'(n_rx), 32'(1 + NV));

    // Backpressure: 6 words, out_rtr low 5 cycles mid-stream.
    rx_base = n_rx;
    fork
      begin
        send(vecs[1],  1'b1, 1'b0);
        send(vecs[2],  1'b0, 1'b0);
        send(vecs[3],  1'b0, 1'b0);
        send(vecs[12], 1'b0, 1'b0);
        send(vecs[13], 1'b0, 1'b0);
        send(vecs[14], 1'b0, 1'b1);
      end
      begin
        for (int t = 0; t < 20; t++) begin
          @(posedge clk); #1;
          if (out_rts) break;
        end
        check_eq("bp_out_rts_seen", 32'(out_rts), 1);
        out_rtr = 1'b0;
        held = out_posit;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check_eq($sformatf("bp_in_rtr_c%0d", c), 32'(in_rtr), 0);
          check_eq($sformatf("bp_rts_c%0d", c), 32'(out_rts), 1);
          check_eq($sformatf("bp_hold_c%0d", c), 32'(out_posit), 32'(held));
          @(posedge clk); #1;
        end
        out_rtr = 1'b1;
      end
    join
    wait_drain();
    check_eq("rx_count_bp", 32'(n_rx - rx_base), 6);

    // Reset with two words in flight.
    out_rtr = 1'b0;
    send(vecs[6], 1'b1, 1'b0);
    send(vecs[7], 1'b0, 1'b1);
    check_eq("rst_mid_pre_rts", 32'(out_rts), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check_eq("rst_mid_rts", 32'(out_rts), 0);
    check_eq("rst_mid_in_rtr", 32'(in_rtr), 1);
    out_rtr = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq($sformatf("rst_mid_idle_c%0d", c), 32'(out_rts), 0);
    end
    @(posedge clk); #1;
    rx_base = n_rx;
    send(vecs[16], 1'b1, 1'b1);
    wait_drain();
    check_eq("rx_count_after_rst", 32'(n_rx - rx_base), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
